// File: rtl/serial_slice_adder.sv
// Multi-cycle add/subtract unit: SLICE chained full-adder cells per clock,
// ripple carry held in a register between slices, start/busy/done handshake.
module serial_slice_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("serial_slice_adder: SLICE must divide WIDTH exactly and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] bx_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] result_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] bx_slice;
  logic [SLICE-1:0] slice_sum;
  logic [SLICE:0]   chain;
  logic             last_slice;

  assign last_slice = (state_reg == RUN) && (cnt_reg == CW'(N - 1));

  assign a_slice  = a_reg[cnt_reg * SLICE +: SLICE];
  assign bx_slice = bx_reg[cnt_reg * SLICE +: SLICE];
  assign chain[0] = carry_reg;

  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
      assign slice_sum[gi] = a_slice[gi] ^ bx_slice[gi] ^ chain[gi];
      assign chain[gi+1]   = (a_slice[gi] & bx_slice[gi]) |
                             (chain[gi] & (a_slice[gi] ^ bx_slice[gi]));
    end
  endgenerate

  // Accumulator with the current slice merged in; on the last slice this is the full result.
  always_comb begin
    acc_next = acc_reg;
    acc_next[cnt_reg * SLICE +: SLICE] = slice_sum;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      a_reg      <= '0;
      bx_reg     <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            // Subtract is A + ~B + ~Cin, so the borrow-in becomes an inverted carry-in.
            a_reg     <= A;
            bx_reg    <= Sub ? ~B : B;
            carry_reg <= Sub ? ~Cin : Cin;
            cnt_reg   <= '0;
            acc_reg   <= '0;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          carry_reg <= chain[SLICE];
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_slice) begin
            result_reg <= acc_next;
            cout_reg   <= chain[SLICE];
            ovf_reg    <= chain[SLICE] ^ chain[SLICE-1];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Busy     = (state_reg != IDLE);
  assign Done     = (state_reg == DONE);
  assign Result   = result_reg;
  assign Cout     = cout_reg;
  assign Overflow = ovf_reg;

endmodule
